uart_tx: RTL and testbench
==========================

# uart_tx

UART serializer that sits directly downstream of the operand/ALU interface stage. It accepts a parallel result word plus a one-cycle start strobe (driven by the interface's data-ready pulse and ALU result). It emits an asynchronous serial frame: start bit, data LSB first, optional parity, stop bit. Bit timing derives from an external 16x oversampling tick so the block shares the baud generator used by the receiver.

## Interface
- NB_DATA, 8, data bits per frame
- TICKS_PER_BIT, 16, oversampling ticks per start/data/parity bit
- SB_TICK, 16, ticks for the stop bit (16 = 1 stop, 24 = 1.5, 32 = 2)
- i_clk  input  1  clock
- i_reset  input  1  reset, asynchronous, active-high
- i_tick  input  1  oversampling tick, one i_clk cycle wide
- i_tx_start  input  1  request to send i_data; sampled only in IDLE
- i_data  input  NB_DATA  word to transmit; latched on acceptance
- o_tx  output  1  serial line, idle high
- o_tx_done  output  1  one-cycle pulse when the stop bit completes
- o_busy  output  1  high from acceptance until o_tx_done inclusive

## Operation
- Reset values: o_tx=1, o_tx_done=0, o_busy=0, state=IDLE, tick count=0, bit count=0, shift register=0.
- States (one-hot): IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1. i_tx_start=1 -> latch i_data into the shift register, clear the tick count, go to START. i_tick is ignored in IDLE.
- START: o_tx=0. On each i_tick, increment the tick count. On the tick where count = TICKS_PER_BIT-1, clear the count and bit count, then go to DATA.
- DATA: o_tx = shift register LSB. On the tick where count = TICKS_PER_BIT-1, shift right, increment the bit count, and clear the tick count. After bit NB_DATA-1, go to PARITY (if enabled) or STOP.
- PARITY: o_tx = even parity of the latched word. Duration TICKS_PER_BIT ticks, then STOP.
- STOP: o_tx=1. On the tick where count = SB_TICK-1, assert o_tx_done for that cycle and go to IDLE.
- i_tx_start while not IDLE (including the o_tx_done cycle): ignored, no queuing. The upstream stage must wait for o_busy=0.
- i_data changes after acceptance do not affect the frame in flight.
- Reset mid-frame: o_tx returns to 1 asynchronously, the frame is abandoned, and no o_tx_done is issued.
- Counter widths: tick count is $clog2(max(TICKS_PER_BIT,SB_TICK)) bits; bit count is $clog2(NB_DATA)+1 bits. No wrap is reachable in legal operation.
- Illegal state encoding -> IDLE with o_tx=1.

## Timing
- o_tx is registered. It falls on the i_clk edge after the cycle in which i_tx_start is accepted (1-cycle latency).
- o_busy rises on the same edge as o_tx falls. It drops on the edge after the o_tx_done cycle.
- Frame length in ticks: TICKS_PER_BIT*(1+NB_DATA) + SB_TICK, plus TICKS_PER_BIT with parity. Defaults give 160, or 176 with parity.
- Each bit boundary occurs on the i_clk edge following the qualifying i_tick.
- Back-to-back: the earliest next acceptance is the first IDLE cycle after o_tx_done.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is compiled in, and one even-parity bit is inserted between the data bits and the stop bit. Parity is computed at acceptance from the latched word.
- Undefined: no PARITY state or parity logic. DATA goes directly to STOP.

## Structure
- Shared package (uart_pkg): state one-hot localparams, default NB_DATA/TICKS_PER_BIT/SB_TICK, and an even-parity function shared with the receiver.
- No internal sub-module. i_tick comes from the existing baud_rate_gen instantiated at top level alongside the receiver.

## Test plan
- Reset with i_tx_start held high -> o_tx=1, o_busy=0, o_tx_done=0; after release, the first IDLE cycle accepts.
- Send 0xA5 (no parity, 16/16) -> o_tx sequence 0,1,0,1,0,0,1,0,1,1, each 16 ticks; o_tx_done pulses once after 160 ticks.
- UART_TX_PARITY_EN, send 0x07 -> parity bit 1 between data and stop; send 0xA5 -> parity bit 0; total 176 ticks.
- Pulse i_tx_start with 0x3C mid-frame and on the o_tx_done cycle -> both ignored, current frame unchanged; a start one cycle after o_tx_done is accepted.
- Change i_data from 0x55 to 0xFF one cycle after acceptance -> serialized word is still 0x55.
- Assert i_reset during DATA bit 3 -> o_tx=1 immediately, o_busy=0, no o_tx_done; a subsequent 0x01 frame transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encoding, default frame geometry and
// the even-parity helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int NB_DATA_DEF       = 8;
  localparam int TICKS_PER_BIT_DEF = 16;
  localparam int SB_TICK_DEF       = 16;  // 16 = 1 stop bit, 24 = 1.5, 32 = 2

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } state_e;

  // Wide enough for any data width either side of the link uses.
  localparam int PARITY_MAX_W = 32;

  // Even parity bit: makes the total count of ones in word+parity even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional even
// parity (compile with UART_TX_PARITY_EN), stop bit, timed by a 16x tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEF,
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF,
  parameter int SB_TICK       = SB_TICK_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy
);

  localparam int TICK_W = $clog2((TICKS_PER_BIT > SB_TICK) ? TICKS_PER_BIT : SB_TICK);
  localparam int BIT_W  = $clog2(NB_DATA) + 1;

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(NB_DATA - 1);

  state_e               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // NOTE: every signal gets a hold-value default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_tx_start) begin
          shift_d  = i_data;
          tick_d   = '0;
          state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(PARITY_MAX_W'(i_data));
`endif
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (i_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = '0;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is decoded from the next state so o_tx leaves a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
    o_tx_done = (state_q == ST_STOP) && i_tick && (tick_q == STOP_LAST);
  end

  assign o_tx   = tx_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of frames plus hand-written reset and
// collision sequences. Follows UART_TX_PARITY_EN if the design is built with it.
module tb_uart_tx;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_tick;
  logic       i_tx_start;
  logic [7:0] i_data;
  logic       o_tx;
  logic       o_tx_done;
  logic       o_busy;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS       = 11;
  localparam int FRAME_TICKS = 176;
`else
  localparam int NBITS       = 10;
  localparam int FRAME_TICKS = 160;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int g_ticks;
  int g_done_cnt;
  int g_done_at;

  uart_tx dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tick     (i_tick),
    .i_tx_start (i_tx_start),
    .i_data     (i_data),
    .o_tx       (o_tx),
    .o_tx_done  (o_tx_done),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle, entered just after a falling edge; o_tx_done is combinational.
  task automatic cyc(input logic tk);
    i_tick = tk;
    #1;
    if (tk) g_ticks++;
    if (o_tx_done) begin
      g_done_cnt++;
      g_done_at = g_ticks;
    end
    @(negedge i_clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
    logic [7:0] late_data;
    bit         glitch;
    string      tag;
  } vec_t;

  // Sends one frame, checking every bit level, done pulse position and busy.
  task automatic send_frame(input vec_t v);
    logic exp_bits [NBITS];
    int   nt;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = v.data[i];
`ifdef UART_TX_PARITY_EN
    exp_bits[9] = v.exp_par;
`endif
    exp_bits[NBITS-1] = 1'b1;
    g_ticks = 0; g_done_cnt = 0; g_done_at = 0;

    i_data = v.data;
    i_tx_start = 1'b1;
    cyc(1'b0);
    i_tx_start = 1'b0;
    i_data = v.late_data;
    check({v.tag, " busy_after_accept"}, 32'(o_busy), 32'd1);

    for (int b = 0; b < NBITS; b++) begin
      check($sformatf("%s bit%0d", v.tag, b), 32'(o_tx), 32'(exp_bits[b]));
      nt = 16;
      for (int t = 0; t < nt; t++) begin
        if (v.glitch && b == 4 && t == 5) begin
          i_tx_start = 1'b1; i_data = 8'h3C;
          cyc(1'b1);
          i_tx_start = 1'b0; i_data = v.late_data;
        end else if (v.glitch && b == NBITS-1 && t == nt-1) begin
          i_tx_start = 1'b1; i_data = 8'h3C;
          cyc(1'b1);
          i_tx_start = 1'b0; i_data = v.late_data;
        end else begin
          cyc(1'b1);
        end
        if (!(b == NBITS-1 && t == nt-1)) begin
          cyc(1'b0); cyc(1'b0); cyc(1'b0);
        end
      end
    end
    check({v.tag, " done_count"}, 32'(g_done_cnt), 32'd1);
    check({v.tag, " done_tick"}, 32'(g_done_at), 32'(FRAME_TICKS));
    check({v.tag, " busy_after_done"}, 32'(o_busy), 32'd0);
    check({v.tag, " tx_idle"}, 32'(o_tx), 32'd1);
  endtask

  vec_t vecs [6];

  initial begin
    // data, even parity (hand-computed), data driven after acceptance, collisions
    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0, "a5"};
    vecs[1] = '{8'h07, 1'b1, 8'h07, 1'b0, "07"};
    vecs[2] = '{8'h55, 1'b0, 8'hFF, 1'b0, "55_late_ff"};
    vecs[3] = '{8'h81, 1'b0, 8'h81, 1'b1, "81_collide"};
    vecs[4] = '{8'h00, 1'b0, 8'h00, 1'b0, "00_back2back"};
    vecs[5] = '{8'hFE, 1'b1, 8'hFE, 1'b0, "fe"};

    // Reset with a start request held high.
    i_reset = 1'b1; i_tick = 1'b0; i_tx_start = 1'b1; i_data = 8'hA5;
    repeat (4) @(negedge i_clk);
    check("rst tx", 32'(o_tx), 32'd1);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst done", 32'(o_tx_done), 32'd0);
    i_reset = 1'b0;

    // First frame is accepted in the first cycle after release.
    for (int i = 0; i < 6; i++) send_frame(vecs[i]);

    // Abort a frame during data bit 3 (0xC3 bit 3 is 0).
    g_ticks = 0; g_done_cnt = 0;
    i_data = 8'hC3; i_tx_start = 1'b1;
    cyc(1'b0);
    i_tx_start = 1'b0;
    for (int t = 0; t < 72; t++) begin
      cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
    end
    check("abort pre_reset tx", 32'(o_tx), 32'd0);
    #2;
    i_reset = 1'b1;
    #1;
    check("abort tx_async", 32'(o_tx), 32'd1);
    check("abort busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    for (int t = 0; t < 20; t++) cyc(1'b1);
    i_reset = 1'b0;
    for (int t = 0; t < 40; t++) begin
      cyc(1'b1); cyc(1'b0);
    end
    check("abort no_done", 32'(g_done_cnt), 32'd0);
    check("abort still_idle", 32'(o_busy), 32'd0);

    send_frame('{8'h01, 1'b1, 8'h01, 1'b0, "01_after_reset"});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule
